// File: rtl/conv_window_gen_if.sv
// Handshake bundle for conv_window_gen: pixel stream in, flattened window stream out.
// The slave modport is the window generator; the master modport is its surroundings.
interface conv_window_gen_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CONV_SIZE  = 9
);
  logic                  i_enable;
  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] i_pixel;
  logic [DATA_WIDTH-1:0] o_window [0:CONV_SIZE-1];
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_frame_done;

  modport master (
    output i_enable, i_valid, i_pixel, i_ready,
    input  o_ready, o_window, o_valid, o_frame_done
  );

  modport slave (
    input  i_enable, i_valid, i_pixel, i_ready,
    output o_ready, o_window, o_valid, o_frame_done
  );
endinterface

// File: rtl/conv_window_gen.sv
// Stride-1, no-padding sliding-window generator: buffers KERNEL_DIM-1 rows and emits
// each complete KERNEL_DIM x KERNEL_DIM window as a row-major flattened vector.
module conv_window_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int KERNEL_DIM = 3,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic            i_clock,
  input  logic            i_reset,
  conv_window_gen_if.slave bus
);

  localparam int CONV_SIZE = KERNEL_DIM * KERNEL_DIM;
  localparam int NBUF      = KERNEL_DIM - 1;
  localparam int CW        = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW        = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  typedef enum logic [1:0] {
    FILL,
    ROW_WARMUP,
    EMIT
  } phase_e;

  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_lineBuf [0:NBUF-1][0:IMG_WIDTH-1];
  logic [DATA_WIDTH-1:0] r_win     [0:KERNEL_DIM-1][0:KERNEL_DIM-1];
  logic                  r_valid;
  logic                  r_frameDone;

  logic [DATA_WIDTH-1:0] w_newCol [0:KERNEL_DIM-1];
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_lastCol;
  logic                  w_lastRow;
  phase_e                w_phase;

  assign w_ready   = bus.i_enable && (!r_valid || bus.i_ready);
  assign w_accept  = bus.i_valid && w_ready;
  assign w_lastCol = (r_col == CW'(IMG_WIDTH - 1));
  assign w_lastRow = (r_row == RW'(IMG_HEIGHT - 1));

  assign bus.o_ready      = w_ready;
  assign bus.o_valid      = r_valid;
  assign bus.o_frame_done = r_frameDone;

  // The window registers stay frozen while a window is held, so they can drive the output directly.
  for (genvar gi = 0; gi < KERNEL_DIM; gi++) begin : g_winRow
    for (genvar gj = 0; gj < KERNEL_DIM; gj++) begin : g_winCol
      assign bus.o_window[gi*KERNEL_DIM + gj] = r_win[gi][gj];
    end
  end

  always_comb begin
    if (r_row < RW'(KERNEL_DIM - 1)) begin
      w_phase = FILL;
    end else if (r_col < CW'(KERNEL_DIM - 1)) begin
      w_phase = ROW_WARMUP;
    end else begin
      w_phase = EMIT;
    end
  end

  // Oldest buffered row lands at the top of the incoming column.
  always_comb begin
    for (int i = 0; i < NBUF; i++) begin
      w_newCol[i] = r_lineBuf[NBUF-1-i][r_col];
    end
    w_newCol[KERNEL_DIM-1] = bus.i_pixel;
  end

  // Line buffers are plain RAM: not reset, stale contents are masked by the counter phases.
  always_ff @(posedge i_clock) begin
    if (w_accept) begin
      r_lineBuf[0][r_col] <= bus.i_pixel;
      for (int k = 1; k < NBUF; k++) begin
        r_lineBuf[k][r_col] <= r_lineBuf[k-1][r_col];
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_col       <= '0;
      r_row       <= '0;
      r_valid     <= 1'b0;
      r_frameDone <= 1'b0;
      for (int i = 0; i < KERNEL_DIM; i++) begin
        for (int j = 0; j < KERNEL_DIM; j++) begin
          r_win[i][j] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int i = 0; i < KERNEL_DIM; i++) begin
        for (int j = 0; j < KERNEL_DIM - 1; j++) begin
          r_win[i][j] <= r_win[i][j+1];
        end
        r_win[i][KERNEL_DIM-1] <= w_newCol[i];
      end
      if (w_lastCol) begin
        r_col <= '0;
        r_row <= w_lastRow ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
      r_valid     <= (w_phase == EMIT);
      r_frameDone <= (w_phase == EMIT) && w_lastRow && w_lastCol;
    end else if (r_valid && bus.i_ready) begin
      r_valid     <= 1'b0;
      r_frameDone <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen: a 4x4 instance for directed/random scenarios
// and a default 28x28 instance for the full-size random frame, both against an image-array model.
module tb_conv_window_gen;

  localparam int DW = 32;

  typedef struct packed {
    logic                done;
    logic [8:0][DW-1:0]  w;
  } win_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstN;
  logic          en, vIn, rdy;
  logic [DW-1:0] pix;
  int            sel;

  conv_window_gen_if #(.DATA_WIDTH(DW), .CONV_SIZE(9)) sIf ();
  conv_window_gen_if #(.DATA_WIDTH(DW), .CONV_SIZE(9)) bIf ();

  assign sIf.i_enable = (sel == 0) ? en   : 1'b0;
  assign sIf.i_valid  = (sel == 0) ? vIn  : 1'b0;
  assign sIf.i_pixel  = pix;
  assign sIf.i_ready  = (sel == 0) ? rdy  : 1'b1;
  assign bIf.i_enable = (sel == 1) ? en   : 1'b0;
  assign bIf.i_valid  = (sel == 1) ? vIn  : 1'b0;
  assign bIf.i_pixel  = pix;
  assign bIf.i_ready  = (sel == 1) ? rdy  : 1'b1;

  conv_window_gen #(.DATA_WIDTH(DW), .KERNEL_DIM(3), .IMG_WIDTH(4), .IMG_HEIGHT(4)) uSmall (
    .i_clock (clk),
    .i_reset (rstN),
    .bus     (sIf)
  );

  conv_window_gen #(.DATA_WIDTH(DW), .KERNEL_DIM(3), .IMG_WIDTH(28), .IMG_HEIGHT(28)) uBig (
    .i_clock (clk),
    .i_reset (rstN),
    .bus     (bIf)
  );

  logic          oReady, oValid, oDone;
  logic [DW-1:0] oWin [9];

  always_comb begin
    oReady = (sel == 1) ? bIf.o_ready      : sIf.o_ready;
    oValid = (sel == 1) ? bIf.o_valid      : sIf.o_valid;
    oDone  = (sel == 1) ? bIf.o_frame_done : sIf.o_frame_done;
    for (int i = 0; i < 9; i++) begin
      oWin[i] = (sel == 1) ? bIf.o_window[i] : sIf.o_window[i];
    end
  end

  // Reference model: the current frame as a 2D image plus a queue of windows owed downstream.
  int            W, H, mr, mc;
  logic [DW-1:0] img [0:27][0:27];
  win_t          expQ [$];
  win_t          gotQ [$];
  logic          expValid;
  int            nChecks = 0;
  int            nErrors = 0;
  int            doneSeen;

  int basicLit [4][9] = '{
    '{1, 2, 3, 5, 6, 7, 9, 10, 11},
    '{2, 3, 4, 6, 7, 8, 10, 11, 12},
    '{5, 6, 7, 9, 10, 11, 13, 14, 15},
    '{6, 7, 8, 10, 11, 12, 14, 15, 16}
  };

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mr = 0;
    mc = 0;
    expValid = 1'b0;
    expQ.delete();
  endtask

  // One clock cycle: drive, check outputs against the model, then advance the model.
  task automatic applyStimulus(input logic ven, input logic vv, input logic [DW-1:0] vp,
                               input logic vr, output logic acc);
    logic drain, emit;
    win_t cur, nw;
    cur = '0;
    nw  = '0;
    en = ven; vIn = vv; pix = vp; rdy = vr;
    #1;
    chk("o_valid", oValid, expValid);
    chk("o_ready", oReady, ven && (!expValid || vr));
    if (expValid && expQ.size() > 0) begin
      for (int i = 0; i < 9; i++) chk($sformatf("window[%0d]", i), oWin[i], expQ[0].w[i]);
      chk("frame_done", oDone, expQ[0].done);
    end else begin
      chk("frame_done_idle", oDone, 1'b0);
    end
    if (oValid === 1'b1 && vr) begin
      for (int i = 0; i < 9; i++) cur.w[i] = oWin[i];
      cur.done = oDone;
      gotQ.push_back(cur);
      if (oDone === 1'b1) doneSeen++;
    end
    drain = expValid && vr;
    acc   = vv && ven && (!expValid || vr);
    emit  = 1'b0;
    if (drain && expQ.size() > 0) void'(expQ.pop_front());
    if (acc) begin
      img[mr][mc] = vp;
      emit = (mr >= 2) && (mc >= 2);
      if (emit) begin
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            nw.w[dr*3+dc] = img[mr-2+dr][mc-2+dc];
        nw.done = (mr == H-1) && (mc == W-1);
        expQ.push_back(nw);
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr++;
        if (mr == H) mr = 0;
      end
    end
    if (acc) expValid = emit;
    else if (drain) expValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, "_count"}, gotQ.size(), 4);
    for (int k = 0; k < 4 && k < gotQ.size(); k++) begin
      for (int i = 0; i < 9; i++)
        chk($sformatf("%s_w%0d[%0d]", tag, k, i), gotQ[k].w[i], basicLit[k][i]);
      chk($sformatf("%s_done%0d", tag, k), gotQ[k].done, (k == 3));
    end
  endtask

  task automatic checkCleared(input string tag);
    chk({tag, "_o_valid"}, oValid, 1'b0);
    chk({tag, "_frame_done"}, oDone, 1'b0);
    for (int i = 0; i < 9; i++) chk($sformatf("%s_window[%0d]", tag, i), oWin[i], '0);
  endtask

  initial begin
    logic acc;
    int   p, hold, offCnt, accCnt;
    logic ven, vr;
    sel = 0; W = 4; H = 4;
    en = 1'b0; vIn = 1'b0; rdy = 1'b0; pix = '0;
    rstN = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkCleared("reset");
    chk("reset_big_o_valid", bIf.o_valid, 1'b0);
    rstN = 1'b1;
    @(negedge clk);

    $display("[TB] basic 4x4 frame");
    gotQ.delete(); doneSeen = 0;
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, DW'(i+1), 1'b1, acc);
    repeat (3) applyStimulus(1'b1, 1'b0, '0, 1'b1, acc);
    checkOutput("basic");
    chk("basic_done_seen", doneSeen, 1);

    $display("[TB] backpressure on first window");
    gotQ.delete(); p = 0; hold = 5;
    for (int t = 0; t < 80 && !(p == 16 && !expValid); t++) begin
      vr = 1'b1;
      if (expValid && hold > 0 && gotQ.size() == 0) begin
        vr = 1'b0;
        hold--;
      end
      applyStimulus(1'b1, (p < 16), DW'(p+1), vr, acc);
      if (acc) p++;
    end
    chk("bp_pixels", p, 16);
    chk("bp_hold_cycles", hold, 0);
    checkOutput("backpressure");

    $display("[TB] random gaps over two frames");
    gotQ.delete(); doneSeen = 0; p = 0;
    for (int t = 0; t < 600 && p < 32; t++) begin
      applyStimulus(1'b1, ($urandom_range(0, 1) == 1) && (p < 32),
                    DW'((p % 16) + 1 + ((p >= 16) ? 100 : 0)), ($urandom_range(0, 1) == 1), acc);
      if (acc) p++;
    end
    for (int t = 0; t < 10 && expValid; t++) applyStimulus(1'b1, 1'b0, '0, 1'b1, acc);
    chk("rand_pixels", p, 32);
    chk("rand_windows", gotQ.size(), 8);
    chk("rand_done_seen", doneSeen, 2);
    for (int k = 4; k < 8 && k < gotQ.size(); k++)
      for (int i = 0; i < 9; i++)
        chk($sformatf("frame2_fresh_w%0d[%0d]", k, i), (gotQ[k].w[i] > 100), 1'b1);

    $display("[TB] asynchronous reset mid-frame");
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b1, DW'(i+1), 1'b1, acc);
    rstN = 1'b0;
    #1;
    checkCleared("async_reset");
    rstN = 1'b1;
    modelReset();
    #1;
    gotQ.delete();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, DW'(i+1), 1'b1, acc);
    repeat (3) applyStimulus(1'b1, 1'b0, '0, 1'b1, acc);
    checkOutput("after_reset");

    $display("[TB] enable low mid-row");
    gotQ.delete(); p = 0; offCnt = 0;
    for (int t = 0; t < 40 && p < 16; t++) begin
      ven = !(p == 6 && offCnt < 3);
      if (!ven) offCnt++;
      applyStimulus(ven, 1'b1, DW'(p+1), 1'b1, acc);
      if (acc) p++;
    end
    repeat (3) applyStimulus(1'b1, 1'b0, '0, 1'b1, acc);
    chk("enable_pixels", p, 16);
    chk("enable_off_cycles", offCnt, 3);
    checkOutput("enable");

    $display("[TB] full 28x28 random frame");
    sel = 1; W = 28; H = 28;
    modelReset();
    gotQ.delete(); doneSeen = 0; accCnt = 0;
    for (int t = 0; t < 784; t++) begin
      applyStimulus(1'b1, 1'b1, DW'($urandom), 1'b1, acc);
      if (acc) accCnt++;
    end
    repeat (3) applyStimulus(1'b1, 1'b0, '0, 1'b1, acc);
    chk("big_throughput", accCnt, 784);
    chk("big_windows", gotQ.size(), 676);
    chk("big_done_seen", doneSeen, 1);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
